// File: rtl/window_pixel_streamer.sv
// Frame-buffered KxK window walker: streams each valid window row-major, one pixel per clock,
// followed by a single gap beat, through a two-stage (read + output) registered pipeline.
module window_pixel_streamer #(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PIX_W-1:0]  load_data,
  input  logic              start,
  input  logic [1:0]        kernel_size,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid,
  output logic              win_first,
  output logic              win_last,
  output logic [5:0]        win_row,
  output logic [5:0]        win_col,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam int unsigned IdxW = $clog2(NPix);
  localparam logic [ADDR_W:0] NPixA = (ADDR_W + 1)'(NPix);

  typedef enum logic [2:0] {StIdle, StStream, StGap, StFlush, StDone} state_e;

  state_e            state_q;
  logic [2:0]        k_q, i_q, j_q;
  logic [5:0]        r_q, c_q;

  logic [PIX_W-1:0]  mem [NPix];
  logic [PIX_W-1:0]  rd_data_q;

  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [5:0]        s1_row_q, s1_col_q;

  logic [2:0]        km1;
  logic [6:0]        r_max, c_max;
  logic [IdxW-1:0]   rd_idx;
  logic              wr_ok;
  logic              in_stream;

  // Every address is < NPix, so IdxW-bit modular math yields the exact row-major index.
  always_comb begin
    km1       = k_q - 3'd1;
    r_max     = 7'(IMG_H) - {4'b0, k_q};
    c_max     = 7'(IMG_W) - {4'b0, k_q};
    rd_idx    = IdxW'({1'b0, r_q} + {4'b0, i_q}) * IdxW'(IMG_W)
              + IdxW'({1'b0, c_q} + {4'b0, j_q});
    wr_ok     = load_en && (state_q == StIdle) && ({1'b0, load_addr} < NPixA);
    in_stream = (state_q == StStream);
  end

  // Frame buffer: not reset, synchronous read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[load_addr[IdxW-1:0]] <= load_data;
    end
    rd_data_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= 3'd3;
      i_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (kernel_size == 2'b11) begin
              cfg_err <= 1'b1;
            end else begin
              k_q     <= 3'd3 + {kernel_size, 1'b0};
              i_q     <= '0;
              j_q     <= '0;
              r_q     <= '0;
              c_q     <= '0;
              busy    <= 1'b1;
              state_q <= StStream;
            end
          end
        end
        StStream: begin
          if (j_q == km1) begin
            j_q <= '0;
            if (i_q == km1) begin
              i_q     <= '0;
              state_q <= StGap;
            end else begin
              i_q <= i_q + 3'd1;
            end
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
        StGap: begin
          if (({1'b0, c_q} == c_max) && ({1'b0, r_q} == r_max)) begin
            state_q <= StFlush;
          end else if ({1'b0, c_q} == c_max) begin
            c_q     <= '0;
            r_q     <= r_q + 6'd1;
            state_q <= StStream;
          end else begin
            c_q     <= c_q + 6'd1;
            state_q <= StStream;
          end
        end
        // Lets the final gap beat leave the pipeline before done is raised.
        StFlush: state_q <= StDone;
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      win_first   <= 1'b0;
      win_last    <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
    end else begin
      s1_valid_q  <= in_stream;
      s1_first_q  <= in_stream && (i_q == 3'd0) && (j_q == 3'd0);
      s1_last_q   <= in_stream && (i_q == km1) && (j_q == km1);
      s1_row_q    <= r_q;
      s1_col_q    <= c_q;
      pixel_out   <= s1_valid_q ? rd_data_q : '0;
      pixel_valid <= s1_valid_q;
      win_first   <= s1_first_q;
      win_last    <= s1_last_q;
      win_row     <= s1_row_q;
      win_col     <= s1_col_q;
    end
  end

endmodule

// File: tb/tb_window_pixel_streamer.sv
// Directed bench for window_pixel_streamer: closed-form per-cycle stream model, a table of
// hand-computed beats checked against captured output, plus reset/config/ignore sequences.
module tb_window_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [11:0] load_addr;
  logic [7:0]  load_data;
  logic        start;
  logic [1:0]  kernel_size;
  logic [7:0]  pixel_out;
  logic        pixel_valid, win_first, win_last;
  logic [5:0]  win_row, win_col;
  logic        busy, done, cfg_err;

  always #5 clk = ~clk;

  window_pixel_streamer #(
    .IMG_W  (16),
    .IMG_H  (16),
    .PIX_W  (8),
    .ADDR_W (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .kernel_size (kernel_size),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .win_first   (win_first),
    .win_last    (win_last),
    .win_row     (win_row),
    .win_col     (win_col),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic       valid;
    logic       first;
    logic       last;
    logic [5:0] row;
    logic [5:0] col;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int         slot;
    int         cyc;
    logic [7:0] pix;
    logic       v, f, l;
    logic [5:0] row, col;
    logic       bz, dn, rc;
  } vec_t;

  localparam int CapN = 5008;
  obs_t cap [3][CapN];
  vec_t vecs [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic obs_t sample();
    obs_t o;
    o = {pixel_out, pixel_valid, win_first, win_last, win_row, win_col, busy, done};
    return o;
  endfunction

  function automatic vec_t mk(input int slot, input int cyc, input int pix, input bit v,
                              input bit f, input bit l, input int row, input int col,
                              input bit bz, input bit dn, input bit rc);
    vec_t t;
    t.slot = slot; t.cyc = cyc; t.pix = 8'(pix); t.v = v; t.f = f; t.l = l;
    t.row = 6'(row); t.col = 6'(col); t.bz = bz; t.dn = dn; t.rc = rc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a run and compares every output cycle with a closed-form model of the stream.
  // Cycle 0 is the cycle right after the edge that samples start.
  task automatic run_stream(input logic [1:0] ks, input int slot, input bit inject);
    int k, nw, wins, per, done_cyc, bad, p, w, b, r, c;
    obs_t o, e;
    logic cfg_seen;
    k = 3 + 2 * int'(ks);
    nw = 17 - k;
    wins = nw * nw;
    per = k * k + 1;
    done_cyc = 2 + wins * per;
    bad = 0;
    cfg_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    kernel_size = ks;
    for (int cyc = 0; cyc <= done_cyc + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        kernel_size = 2'b11;
      end
      if (inject && cyc == 20) begin
        start = 1'b1;
        load_en = 1'b1;
        load_addr = '0;
        load_data = 8'hAA;
      end
      if (inject && cyc == 21) begin
        start = 1'b0;
        load_en = 1'b0;
      end
      o = sample();
      if (cyc < CapN) cap[slot][cyc] = o;
      e = '0;
      p = cyc - 2;
      if (p >= 0 && p < wins * per) begin
        w = p / per;
        b = p % per;
        if (b < k * k) begin
          r = w / nw;
          c = w % nw;
          e.pix = 8'((r + b / k) * 16 + c + b % k);
          e.valid = 1'b1;
          e.first = (b == 0);
          e.last = (b == k * k - 1);
          e.row = 6'(r);
          e.col = 6'(c);
        end
      end
      e.busy = (cyc < done_cyc);
      e.done = (cyc == done_cyc);
      if (!e.valid) begin
        o.row = '0;
        o.col = '0;
      end
      if (o !== e) bad++;
      if (cfg_err) cfg_seen = 1'b1;
    end
    chk($sformatf("stream_ks%0d_bad_cycles", ks), 64'(bad), 64'd0);
    chk($sformatf("stream_ks%0d_no_cfg_err", ks), 64'(cfg_seen), 64'd0);
  endtask

  initial begin
    logic done_seen;
    obs_t a, e;

    // slot, cyc, pix, valid, first, last, row, col, busy, done, check row/col
    vecs.push_back(mk(0,    0,   0, 0, 0, 0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(0,    2,   0, 1, 1, 0,  0,  0, 1, 0, 1));
    vecs.push_back(mk(0,    3,   1, 1, 0, 0,  0,  0, 1, 0, 1));
    vecs.push_back(mk(0,    5,  16, 1, 0, 0,  0,  0, 1, 0, 1));
    vecs.push_back(mk(0,   10,  34, 1, 0, 1,  0,  0, 1, 0, 1));
    vecs.push_back(mk(0,   11,   0, 0, 0, 0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(0,   12,   1, 1, 1, 0,  0,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1952, 221, 1, 1, 0, 13, 13, 1, 0, 1));
    vecs.push_back(mk(0, 1960, 255, 1, 0, 1, 13, 13, 1, 0, 1));
    vecs.push_back(mk(0, 1962,   0, 0, 0, 0,  0,  0, 0, 1, 0));
    vecs.push_back(mk(2,    2,   0, 1, 1, 0,  0,  0, 1, 0, 1));
    vecs.push_back(mk(2,   50, 102, 1, 0, 1,  0,  0, 1, 0, 1));
    vecs.push_back(mk(2,   51,   0, 0, 0, 0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(2, 4952, 153, 1, 1, 0,  9,  9, 1, 0, 1));
    vecs.push_back(mk(2, 5002,   0, 0, 0, 0,  0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 3720, 187, 1, 1, 0, 11, 11, 1, 0, 1));
    vecs.push_back(mk(1, 3744, 255, 1, 0, 1, 11, 11, 1, 0, 1));
    vecs.push_back(mk(1, 3745,   0, 0, 0, 0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 3746,   0, 0, 0, 0,  0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 3747,   0, 0, 0, 0,  0,  0, 0, 0, 0));

    reset_n = 1'b0;
    start = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    kernel_size = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({sample(), cfg_err}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      load_en = 1'b1;
      load_addr = 12'(i);
      load_data = 8'(i);
    end
    // Out-of-range writes; 256 and 4095 alias to low addresses if not dropped.
    @(negedge clk);
    load_addr = 12'd256;
    load_data = 8'h55;
    @(negedge clk);
    load_addr = 12'hFFF;
    load_data = 8'h77;
    @(negedge clk);
    load_en = 1'b0;

    @(negedge clk);
    start = 1'b1;
    kernel_size = 2'b11;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 64'({cfg_err, busy, pixel_valid, done}), 64'b1000);
    @(negedge clk);
    chk("cfg_err_clear", 64'({cfg_err, busy, pixel_valid, done}), 64'd0);
    repeat (3) @(negedge clk);
    chk("cfg_err_stays_idle", 64'({cfg_err, busy, pixel_valid, done}), 64'd0);

    run_stream(2'b00, 0, 1'b1);
    run_stream(2'b10, 2, 1'b0);
    run_stream(2'b01, 1, 1'b0);

    // Reset during window 5 (output cycles 52..61).
    done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    kernel_size = 2'b00;
    for (int cyc = 0; cyc <= 54; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (done) done_seen = 1'b1;
    end
    chk("window5_beat2", 64'({pixel_valid, win_first, pixel_out, win_col}), 64'({1'b1, 1'b0, 8'd7, 6'd5}));
    reset_n = 1'b0;
    @(negedge clk);
    chk("reset_midstream_outputs", 64'({sample(), cfg_err}), 64'd0);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || pixel_valid) done_seen = 1'b1;
    end
    chk("reset_midstream_quiet", 64'(done_seen), 64'd0);
    run_stream(2'b00, 0, 1'b0);

    foreach (vecs[n]) begin
      a = cap[vecs[n].slot][vecs[n].cyc];
      e = {vecs[n].pix, vecs[n].v, vecs[n].f, vecs[n].l, vecs[n].row, vecs[n].col,
           vecs[n].bz, vecs[n].dn};
      if (!vecs[n].rc) begin
        a.row = '0;
        a.col = '0;
      end
      chk($sformatf("vec%0d_slot%0d_cyc%0d", n, vecs[n].slot, vecs[n].cyc), 64'(a), 64'(e));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
